// File: rtl/div_pkg.sv
// Shared constants, FSM state encoding and result payload for the 16/8 sequential divider.
// DIV_APPROX_EN (see div_16x8_seq) selects the iteration count used from here.
package div_pkg;

  localparam int unsigned DIVIDEND_W  = 16;
  localparam int unsigned DIVISOR_W   = 8;
  localparam int unsigned QUOTIENT_W  = 8;
  localparam int unsigned REMAINDER_W = 8;
  localparam int unsigned PR_W        = DIVISOR_W + 1;

  localparam int unsigned ITER_EXACT  = 8;
  localparam int unsigned ITER_APPROX = 4;
  localparam int unsigned CNT_W       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [QUOTIENT_W-1:0]  quotient;
    logic [REMAINDER_W-1:0] remainder;
    logic                   err;
  } rsp_t;

  // Quotient cannot fit in 8 bits when the upper dividend byte reaches the divisor.
  function automatic logic div_err(input logic [DIVISOR_W-1:0] dvd_hi,
                                   input logic [DIVISOR_W-1:0] dsr);
    return (dsr == '0) || (dvd_hi >= dsr);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [PR_W-1:0]      pr_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [PR_W-1:0]      pr_out_c,
  output logic                 qbit_c
);

  localparam int unsigned WIDE_W = PR_W + 1;

  logic [WIDE_W-1:0] shifted;
  logic [WIDE_W-1:0] diff;

  always_comb begin
    shifted  = {pr_in, bit_in};
    diff     = shifted - WIDE_W'(divisor);
    qbit_c   = (shifted >= WIDE_W'(divisor));
    pr_out_c = qbit_c ? PR_W'(diff) : PR_W'(shifted);
  end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential 16/8 unsigned restoring divider with valid/ready handshakes on both sides.
// Define DIV_APPROX_EN for a 4-iteration approximate quotient (bits 7:4 only, remainder 0).
module div_16x8_seq
  import div_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIVIDEND_W-1:0]  dividend,
  input  logic [DIVISOR_W-1:0]   divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [QUOTIENT_W-1:0]  quotient,
  output logic [REMAINDER_W-1:0] remainder,
  output logic                   err
);

`ifdef DIV_APPROX_EN
  localparam int unsigned ITER = ITER_APPROX;
`else
  localparam int unsigned ITER = ITER_EXACT;
`endif

  state_t state, state_nxt;

  logic [PR_W-1:0]       pr;
  logic [DIVISOR_W-1:0]  lo;
  logic [DIVISOR_W-1:0]  dsr;
  logic [QUOTIENT_W-1:0] q;
  logic [CNT_W-1:0]      cnt;
  rsp_t                  rsp;

  logic                  accept_c;
  logic                  err_c;
  logic                  last_c;
  logic [PR_W-1:0]       pr_step_c;
  logic                  qbit_c;
  logic [QUOTIENT_W-1:0] q_nxt_c;

  div_step u_step (
    .pr_in    (pr),
    .bit_in   (lo[DIVISOR_W-1]),
    .divisor  (dsr),
    .pr_out_c (pr_step_c),
    .qbit_c   (qbit_c)
  );

  assign q_nxt_c   = {q[QUOTIENT_W-2:0], qbit_c};
  assign quotient  = rsp.quotient;
  assign remainder = rsp.remainder;
  assign err       = rsp.err;

  // State register; handshake flags follow the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    err_c     = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_c  = 1'b1;
          err_c     = div_err(dividend[DIVIDEND_W-1 -: DIVISOR_W], divisor);
          state_nxt = err_c ? DONE : CALC;
        end
      end
      CALC: begin
        last_c = (cnt == CNT_W'(ITER - 1));
        if (last_c) state_nxt = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr  <= '0;
      lo  <= '0;
      dsr <= '0;
      q   <= '0;
      cnt <= '0;
      rsp <= '0;
    end else if (accept_c) begin
      if (err_c) begin
        rsp.quotient  <= '1;
        rsp.remainder <= '1;
        rsp.err       <= 1'b1;
      end else begin
        pr  <= {1'b0, dividend[DIVIDEND_W-1 -: DIVISOR_W]};
        lo  <= dividend[DIVISOR_W-1:0];
        dsr <= divisor;
        q   <= '0;
        cnt <= '0;
      end
    end else if (state == CALC) begin
      pr  <= pr_step_c;
      lo  <= {lo[DIVISOR_W-2:0], 1'b0};
      q   <= q_nxt_c;
      cnt <= last_c ? '0 : cnt + CNT_W'(1);
      if (last_c) begin
`ifdef DIV_APPROX_EN
        rsp.quotient  <= {q_nxt_c[ITER_APPROX-1:0], {(QUOTIENT_W-ITER_APPROX){1'b0}}};
        rsp.remainder <= '0;
`else
        rsp.quotient  <= q_nxt_c;
        rsp.remainder <= pr_step_c[REMAINDER_W-1:0];
`endif
        rsp.err       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_16x8_seq.sv
// Randomised and directed bench for div_16x8_seq against an arithmetic reference model.
module tb_div_16x8_seq;

`ifdef DIV_APPROX_EN
  localparam int EXP_LAT = 5;
`else
  localparam int EXP_LAT = 9;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_16x8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer division; error when divisor is zero or quotient exceeds a byte.
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic e);
    int unsigned qi;
    int unsigned ri;
    if (b == 0) begin
      e = 1'b1; q = 8'hFF; r = 8'hFF;
    end else begin
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
      if (qi > 255) begin
        e = 1'b1; q = 8'hFF; r = 8'hFF;
      end else begin
        e = 1'b0;
`ifdef DIV_APPROX_EN
        q = 8'(qi) & 8'hF0;
        r = 8'h00;
`else
        q = 8'(qi);
        r = 8'(ri);
`endif
      end
    end
  endtask

  task automatic run_req(input logic [15:0] a, input logic [7:0] b, input int hold);
    logic [7:0] eq, er;
    logic       ee;
    int         lat;
    ref_div(a, b, eq, er, ee);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (in_ready !== 1'b0) check("in_ready_busy", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), ee ? 32'd1 : 32'(EXP_LAT));
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("err", 32'(err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_q", 32'({quotient, remainder, err}), 32'({eq, er, ee}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    check("post_hold", 32'({quotient, remainder, err}), 32'({eq, er, ee}));
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'({quotient, remainder, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);

    run_req(16'd1000, 8'd7, 0);
    run_req(16'hFEFF, 8'hFF, 2);
    run_req(16'h0800, 8'h08, 0);
    run_req(16'h1234, 8'h00, 5);
    run_req(16'h0000, 8'h01, 0);
    run_req(16'h00FF, 8'h01, 1);
    run_req(16'h0100, 8'h01, 0);
    run_req(16'd1000, 8'd7, 5);

    // Reset pulse in the middle of CALC discards the operation.
    @(negedge clk);
    in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_out", 32'({quotient, remainder, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_idle", 32'({in_ready, out_valid}), 32'b10);
    run_req(16'd1000, 8'd7, 0);

    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom_range(1, 255));
      if (n % 4 == 3) a = 16'($urandom);
      else a = {8'($urandom_range(0, int'(b) - 1)), 8'($urandom)};
      if (n == 20) b = 8'h00;
      run_req(a, b, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
